dram_axi_rd_slv: RTL and testbench
==================================

// Module: dram_axi_rd_slv
// PURPOSE
// - AXI-style read slave on the DRAM side of the LSU's read port (lsu_axi_ar*/r*).
// - Accepts one read-address request at a time and serves arlen+1 64-bit beats from a local word-addressed memory.
// - Supports optional stride stepping and returns rdata/rresp/rlast with rvld/rrdy flow control.
// - A write port preloads memory; the write datapath and the testbench both use it.
// PARAMETERS
// - AW      10  address width, in 64-bit words; depth = 2**AW.
// - DW      64  data width; must equal 64.
// - IDW      8  AXI ID width.
// PORTS
// - clk            in   1     clock, rising edge
// - rst            in   1     async reset, active-high
// - lsu_axi_arid   in   IDW   read ID, echoed on rid
// - lsu_axi_araddr in   AW    start word address
// - lsu_axi_arlen  in   8     beats-1
// - lsu_axi_arsize in   3     must be 3'd3 (8 B)
// - lsu_axi_arburst in  2     0=FIXED 1=INCR 2/3=unsupported
// - lsu_axi_arstr  in   3     INCR step = 1<<arstr words
// - lsu_axi_arvld  in   1     AR valid
// - axi_lsu_arrdy  out  1     AR ready
// - axi_lsu_rid    out  IDW   read ID
// - axi_lsu_rdata  out  DW    read data
// - axi_lsu_rresp  out  2     00 OKAY, 10 SLVERR
// - axi_lsu_rlast  out  1     final beat
// - axi_lsu_rvld   out  1     R valid
// - lsu_axi_rrdy   in   1     R ready
// - mem_we         in   1     preload write enable
// - mem_waddr      in   AW    preload word address
// - mem_wdata      in   DW    preload data
// BEHAVIOUR
// Reset
// - Every output is 0 at reset, including arrdy=0; the FSM goes to IDLE.
// - Memory contents are not reset.
// FSM
// - IDLE: arrdy=1.
//   - On arvld&arrdy, latch id, addr, len, burst and step; beat_cnt=0.
//   - Issue the SRAM read at araddr in the same cycle; go to FETCH.
// - FETCH: arrdy=0. SRAM data (1-cycle read latency) is registered into rdata.
//   - rvld=1, rlast=(beat_cnt==len); go to DATA.
// - DATA: hold rid/rdata/rresp/rlast stable while rvld & !rrdy.
//   - On rvld&rrdy with !rlast: beat_cnt++, addr += step, issue the next read, rvld=0, go to FETCH.
//   - On rvld&rrdy with rlast: rvld=0, go to IDLE. arrdy rises in the next cycle.
// Timing
// - First beat is valid 2 cycles after the AR handshake.
// - Steady state is 1 beat per 2 cycles when rrdy is held high.
// Address arithmetic
// - FIXED: addr never changes.
// - INCR: addr = (addr + (1<<arstr)) mod 2**AW. Wrap-around past the top address is legal and silent.
// Errors
// - arburst in {2,3} or arsize!=3: full arlen+1 beats are still returned, with rresp=2'b10 and rdata=0. No memory read is issued.
// - Otherwise rresp=2'b00.
// Collisions
// - mem_we to the address read in the same cycle: the read returns old data and the write completes.
// - mem_we is honoured in every state.
// - arvld outside IDLE is ignored (arrdy=0).
// - rrdy may be asserted early; it has no effect without rvld.
// Reset mid-burst
// - The burst is abandoned: rvld drops asynchronously and the FSM goes to IDLE.
// - No partial rlast is ever produced.
// STRUCTURE
// - Shared pkg (axi_pkg): burst enc BURST_FIXED/INCR, resp enc RESP_OKAY/SLVERR, SIZE_8B, and a typedef for the FSM state enum {IDLE, FETCH, DATA}.
// - One sub-module, dram_sp_sram: 1R1W, sync read with 1-cycle latency, read-old-on-collision, AW/DW params.
// - Top holds the FSM, burst counters, address stepping and R-channel registers.
// TESTING
// - Single-beat INCR: preload mem[5]=64'hA5; AR addr=5, len=0, id=8'h3C -> one beat, rdata=A5, rid=3C, rlast=1, rresp=0; arrdy back 1 cycle later.
// - Strided INCR: mem[i]=i; addr=2, len=3, str=1 -> rdata 2,4,6,8; rlast only on the 4th beat.
// - Wrap: addr=1022, len=3, str=0 -> rdata from words 1022, 1023, 0, 1.
// - Backpressure: len=1 with rrdy low for 5 cycles on beat 0 -> rvld, rdata and rlast held stable; no beat lost or duplicated.
// - Error burst: arburst=2, len=2 -> 3 beats, rresp=2'b10, rdata=0; arsize=2 gives the same response.
// - Reset mid-burst: assert rst during beat 1 of len=7 -> rvld=0 immediately. After release, a new AR (FIXED, addr=9, len=1) returns mem[9] twice.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings and read-slave FSM state type.
// Used by the DRAM-side read slave and its testbench.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_8B     = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } rd_state_e;

    // Only 8-byte FIXED/INCR bursts are served from memory.
    function automatic logic ar_is_err(input logic [1:0] burst,
                                       input logic [2:0] size);
        return (burst != BURST_FIXED && burst != BURST_INCR) ||
               (size != SIZE_8B);
    endfunction

endpackage

// File: rtl/dram_axi_rd_slv_sram.sv
// 1R1W word memory, registered read port, old data on collision.
// Contents are intentionally not reset.
module dram_sp_sram #(
    parameter int AW = 10,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dram_axi_rd_slv.sv
// AXI read slave serving one burst at a time from a local word memory.
// One beat per two cycles: FETCH registers SRAM data, DATA waits for rrdy.
module dram_axi_rd_slv
    import axi_pkg::*;
#(
    parameter int AW  = 10,
    parameter int DW  = 64,
    parameter int IDW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDW-1:0] lsu_axi_arid,
    input  logic [AW-1:0]  lsu_axi_araddr,
    input  logic [7:0]     lsu_axi_arlen,
    input  logic [2:0]     lsu_axi_arsize,
    input  logic [1:0]     lsu_axi_arburst,
    input  logic [2:0]     lsu_axi_arstr,
    input  logic           lsu_axi_arvld,
    output logic           axi_lsu_arrdy,
    output logic [IDW-1:0] axi_lsu_rid,
    output logic [DW-1:0]  axi_lsu_rdata,
    output logic [1:0]     axi_lsu_rresp,
    output logic           axi_lsu_rlast,
    output logic           axi_lsu_rvld,
    input  logic           lsu_axi_rrdy,
    input  logic           mem_we,
    input  logic [AW-1:0]  mem_waddr,
    input  logic [DW-1:0]  mem_wdata
);

    rd_state_e      state_q;
    logic [IDW-1:0] id_q;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  addr_d;
    logic [AW-1:0]  step_q;
    logic [7:0]     len_q;
    logic [7:0]     cnt_q;
    logic           err_q;

    logic           arrdy_q;
    logic           rvld_q;
    logic           rlast_q;
    logic [IDW-1:0] rid_q;
    logic [DW-1:0]  rdata_q;
    logic [1:0]     rresp_q;

    logic           ar_hs;
    logic           r_hs;
    logic           ar_err;
    logic           sram_re;
    logic [AW-1:0]  sram_raddr;
    logic [DW-1:0]  sram_rdata;

    assign ar_hs  = lsu_axi_arvld & arrdy_q;
    assign r_hs   = rvld_q & lsu_axi_rrdy;
    assign ar_err = ar_is_err(lsu_axi_arburst, lsu_axi_arsize);
    assign addr_d = addr_q + step_q;

    // Reads are launched on the handshake edge so FETCH sees the data.
    always_comb begin
        sram_re    = 1'b0;
        sram_raddr = addr_d;
        if (state_q == IDLE && ar_hs) begin
            sram_re    = ~ar_err;
            sram_raddr = lsu_axi_araddr;
        end else if (state_q == DATA && r_hs && !rlast_q) begin
            sram_re    = ~err_q;
            sram_raddr = addr_d;
        end
    end

    dram_sp_sram #(
        .AW(AW),
        .DW(DW)
    ) u_sram (
        .clk    (clk),
        .we_i   (mem_we),
        .waddr_i(mem_waddr),
        .wdata_i(mem_wdata),
        .re_i   (sram_re),
        .raddr_i(sram_raddr),
        .rdata_o(sram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            step_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            arrdy_q <= 1'b0;
            rvld_q  <= 1'b0;
            rlast_q <= 1'b0;
            rid_q   <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ar_hs) begin
                        id_q    <= lsu_axi_arid;
                        addr_q  <= lsu_axi_araddr;
                        len_q   <= lsu_axi_arlen;
                        cnt_q   <= '0;
                        err_q   <= ar_err;
                        step_q  <= (lsu_axi_arburst == BURST_INCR) ?
                                   ({{(AW-1){1'b0}}, 1'b1} << lsu_axi_arstr) :
                                   '0;
                        arrdy_q <= 1'b0;
                        state_q <= FETCH;
                    end else begin
                        arrdy_q <= 1'b1;
                    end
                end
                FETCH: begin
                    rvld_q  <= 1'b1;
                    rid_q   <= id_q;
                    rdata_q <= err_q ? '0 : sram_rdata;
                    rresp_q <= err_q ? RESP_SLVERR : RESP_OKAY;
                    rlast_q <= (cnt_q == len_q);
                    state_q <= DATA;
                end
                DATA: begin
                    if (r_hs) begin
                        rvld_q  <= 1'b0;
                        rlast_q <= 1'b0;
                        if (rlast_q) begin
                            arrdy_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 8'd1;
                            addr_q  <= addr_d;
                            state_q <= FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign axi_lsu_arrdy = arrdy_q;
    assign axi_lsu_rvld  = rvld_q;
    assign axi_lsu_rlast = rlast_q;
    assign axi_lsu_rid   = rid_q;
    assign axi_lsu_rdata = rdata_q;
    assign axi_lsu_rresp = rresp_q;

endmodule

// File: tb/tb_dram_axi_rd_slv.sv
// Scoreboard bench for dram_axi_rd_slv: directed cases plus random bursts.
// Expected beats come from a flat memory model and burst arithmetic.
module tb_dram_axi_rd_slv;

    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int IDW   = 8;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic [1:0]     resp;
        logic           last;
    } beat_t;

    logic           clk;
    logic           rst;
    logic [IDW-1:0] arid;
    logic [AW-1:0]  araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic [2:0]     arstr;
    logic           arvld;
    logic           arrdy;
    logic [IDW-1:0] rid;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rvld;
    logic           rrdy;
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [DW-1:0]  mem_wdata;

    logic [DW-1:0]  mdl [DEPTH];
    beat_t          exq [$];

    int checks   = 0;
    int failures = 0;
    int pop_cnt  = 0;
    bit rand_mode = 0;
    bit bp_hold   = 0;

    dram_axi_rd_slv #(
        .AW(AW),
        .DW(DW),
        .IDW(IDW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_axi_arid   (arid),
        .lsu_axi_araddr (araddr),
        .lsu_axi_arlen  (arlen),
        .lsu_axi_arsize (arsize),
        .lsu_axi_arburst(arburst),
        .lsu_axi_arstr  (arstr),
        .lsu_axi_arvld  (arvld),
        .axi_lsu_arrdy  (arrdy),
        .axi_lsu_rid    (rid),
        .axi_lsu_rdata  (rdata),
        .axi_lsu_rresp  (rresp),
        .axi_lsu_rlast  (rlast),
        .axi_lsu_rvld   (rvld),
        .lsu_axi_rrdy   (rrdy),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .mem_wdata      (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // R-channel ready: random, forced low for backpressure, or high.
    initial begin
        rrdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_hold)
                rrdy = 1'b0;
            else if (rand_mode)
                rrdy = 1'($urandom_range(0, 1));
            else
                rrdy = 1'b1;
        end
    end

    // Monitor: stability under backpressure and in-order beat compare.
    initial begin
        bit             prev_p;
        logic [DW-1:0]  prev_d;
        logic           prev_l;
        logic [IDW-1:0] prev_id;
        beat_t          e;
        prev_p = 0;
        prev_d = '0;
        prev_l = 0;
        prev_id = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_p = 0;
            end else begin
                if (prev_p) begin
                    chk("hold_rvld", 64'(rvld), 64'd1);
                    chk("hold_rdata", rdata, prev_d);
                    chk("hold_rlast", 64'(rlast), 64'(prev_l));
                    chk("hold_rid", 64'(rid), 64'(prev_id));
                end
                if (rvld && rrdy) begin
                    if (exq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: rdata %h with empty queue", rdata);
                    end else begin
                        e = exq.pop_front();
                        chk("rid", 64'(rid), 64'(e.id));
                        chk("rdata", rdata, e.data);
                        chk("rresp", 64'(rresp), 64'(e.resp));
                        chk("rlast", 64'(rlast), 64'(e.last));
                        pop_cnt++;
                    end
                end
                prev_p  = rvld && !rrdy;
                prev_d  = rdata;
                prev_l  = rlast;
                prev_id = rid;
            end
        end
    end

    task automatic wr(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        mem_we    = 1'b1;
        mem_waddr = AW'(a);
        mem_wdata = d;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic issue_ar(input int id, input int addr, input int len,
                            input int burst, input int size, input int str);
        bit    ok;
        bit    err;
        int    a;
        beat_t b;
        ok = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (arrdy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            timeout("ar_wait_arrdy");
            return;
        end
        err = (burst > 1) || (size != 3);
        for (int i = 0; i <= len; i++) begin
            a = (burst == 0) ? addr : (addr + i * (1 << str)) % DEPTH;
            b.id   = IDW'(id);
            b.data = err ? '0 : mdl[a];
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == len);
            exq.push_back(b);
        end
        arid    = IDW'(id);
        araddr  = AW'(addr);
        arlen   = 8'(len);
        arburst = 2'(burst);
        arsize  = 3'(size);
        arstr   = 3'(str);
        arvld   = 1'b1;
        @(posedge clk);
        #1;
        arvld = 1'b0;
    endtask

    task automatic drain(input string nm);
        bit ok;
        ok = 0;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (exq.size() == 0 && !rvld) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout(nm);
    endtask

    task automatic wait_rvld(input string nm);
        bit ok;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (rvld) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout(nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [DW-1:0] oldv;
        rst = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd3;
        arburst = 2'd1; arstr = '0; arvld = 1'b0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_arrdy", 64'(arrdy), 64'd0);
        chk("rst_rvld", 64'(rvld), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        chk("rst_rid", 64'(rid), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            mem_we    = 1'b1;
            mem_waddr = AW'(i);
            mem_wdata = DW'(i);
            mdl[i]    = DW'(i);
        end
        @(negedge clk);
        mem_we = 1'b0;

        // Single-beat INCR with latency and arrdy-return checks.
        wr(5, 64'hA5);
        issue_ar(8'h3C, 5, 0, 1, 3, 0);
        @(negedge clk);
        chk("lat_rvld_early", 64'(rvld), 64'd0);
        @(negedge clk);
        chk("lat_rvld_first", 64'(rvld), 64'd1);
        @(negedge clk);
        chk("post_rvld", 64'(rvld), 64'd0);
        chk("post_arrdy", 64'(arrdy), 64'd1);
        drain("single");

        issue_ar(1, 2, 3, 1, 3, 1);
        drain("stride");
        issue_ar(2, 1022, 3, 1, 3, 0);
        drain("wrap");
        issue_ar(3, 50, 2, 0, 3, 2);
        drain("fixed");

        bp_hold = 1;
        issue_ar(4, 20, 1, 1, 3, 0);
        wait_rvld("bp_first");
        repeat (5) @(negedge clk);
        bp_hold = 0;
        drain("backpressure");

        issue_ar(5, 30, 2, 2, 3, 0);
        issue_ar(6, 30, 2, 1, 2, 0);
        drain("err");

        // Read and write of the same word on the handshake edge.
        oldv = mdl[100];
        exq.push_back('{id: 8'h77, data: oldv, resp: 2'b00, last: 1'b1});
        seen = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (arrdy) begin
                seen = 1;
                break;
            end
        end
        if (seen == 0) timeout("coll_arrdy");
        arid = 8'h77; araddr = 10'd100; arlen = 8'd0;
        arburst = 2'd1; arsize = 3'd3; arstr = 3'd0; arvld = 1'b1;
        mem_we = 1'b1; mem_waddr = 10'd100; mem_wdata = 64'hDEAD_BEEF_0000_1234;
        @(posedge clk);
        #1;
        arvld = 1'b0;
        mem_we = 1'b0;
        mdl[100] = 64'hDEAD_BEEF_0000_1234;
        drain("collision");
        issue_ar(8, 100, 0, 1, 3, 0);
        drain("collision_after");

        // Reset during beat 1 of an 8-beat burst.
        issue_ar(7, 40, 7, 1, 3, 0);
        seen = 0;
        for (int t = 0; t < 100 && seen < 2; t++) begin
            @(negedge clk);
            if (rvld) seen++;
        end
        if (seen < 2) timeout("rst_mid_wait");
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_rvld", 64'(rvld), 64'd0);
        chk("rst_mid_rlast", 64'(rlast), 64'd0);
        chk("rst_mid_arrdy", 64'(arrdy), 64'd0);
        exq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue_ar(9, 9, 1, 0, 3, 0);
        drain("post_rst");

        // Randomized bursts with random R-channel ready.
        rand_mode = 1;
        for (int n = 0; n < 60; n++) begin
            int bu;
            int sz;
            if ($urandom_range(0, 3) == 0) begin
                drain("rand_pre_wr");
                wr($urandom_range(0, DEPTH - 1), {$urandom, $urandom});
            end
            bu = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 3) :
                                               $urandom_range(0, 1);
            sz = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : 3;
            issue_ar($urandom_range(0, 255), $urandom_range(0, DEPTH - 1),
                     $urandom_range(0, 7), bu, sz, $urandom_range(0, 7));
        end
        drain("rand_end");
        rand_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
